// File: rtl/nem_ohmux_sel_seq_2i_if.sv
// Request handshake and relay drive bundle between the select requester and
// the break-before-make sequencer for the 2-input NEM relay mux.
interface nem_ohmux_sel_seq_2i_if;
   logic       REQ_VALID;
   logic [1:0] REQ_SEL;
   logic       REQ_READY;
   logic       S0;
   logic       S1;
   logic       SEL_VALID;
   logic [1:0] CUR_SEL;
   logic       ERR;

   modport master (
      output REQ_VALID, REQ_SEL,
      input  REQ_READY, S0, S1, SEL_VALID, CUR_SEL, ERR
   );

   modport slave (
      input  REQ_VALID, REQ_SEL,
      output REQ_READY, S0, S1, SEL_VALID, CUR_SEL, ERR
   );
endinterface

// File: rtl/nem_ohmux_sel_seq_2i.sv
// Break-before-make select sequencer for the 2-input inverting one-hot NEM
// relay mux: opens the closed relay, waits release time, then closes the new one.
module nem_ohmux_sel_seq_2i #(
   parameter int OFF_CYCLES = 3,
   parameter int ON_CYCLES  = 4,
   parameter int CNT_W      = 8
) (
   input  logic                 CP,
   input  logic                 RST,
   nem_ohmux_sel_seq_2i_if.slave bus
);

   typedef enum logic [1:0] {
      PARKED,
      ON_WAIT,
      STABLE,
      OFF_WAIT
   } state_t;

   localparam logic [CNT_W-1:0] ON_LOAD  = CNT_W'(ON_CYCLES - 1);
   localparam logic [CNT_W-1:0] OFF_LOAD = CNT_W'(OFF_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       s_q, s_d;
   logic             sel_valid_q, sel_valid_d;
   logic [1:0]       cur_sel_q, cur_sel_d;
   logic             err_q, err_d;
   logic             req_ready;
   logic             accept;

   assign req_ready = !RST && ((state_q == PARKED) || (state_q == STABLE));
   assign accept    = bus.REQ_VALID && req_ready;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      s_d         = s_q;
      sel_valid_d = sel_valid_q;
      cur_sel_d   = cur_sel_q;
      err_d       = err_q;

      unique case (state_q)
         PARKED: begin
            if (accept) begin
               if (bus.REQ_SEL == 2'd3) begin
                  err_d = 1'b1;
               end else if (bus.REQ_SEL != 2'd0) begin
                  s_d       = (bus.REQ_SEL == 2'd1) ? 2'b01 : 2'b10;
                  cur_sel_d = bus.REQ_SEL;
                  cnt_d     = ON_LOAD;
                  state_d   = ON_WAIT;
               end
            end
         end
         ON_WAIT: begin
            if (cnt_q == '0) begin
               sel_valid_d = 1'b1;
               state_d     = STABLE;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         STABLE: begin
            if (accept) begin
               if (bus.REQ_SEL == 2'd3) begin
                  err_d = 1'b1;
               end else if (bus.REQ_SEL != cur_sel_q) begin
                  // Open first; the new relay only closes after the release settle.
                  s_d         = 2'b00;
                  sel_valid_d = 1'b0;
                  cur_sel_d   = bus.REQ_SEL;
                  cnt_d       = OFF_LOAD;
                  state_d     = OFF_WAIT;
               end
            end
         end
         OFF_WAIT: begin
            if (cnt_q == '0) begin
               if (cur_sel_q == 2'd0) begin
                  state_d = PARKED;
               end else begin
                  s_d     = (cur_sel_q == 2'd1) ? 2'b01 : 2'b10;
                  cnt_d   = ON_LOAD;
                  state_d = ON_WAIT;
               end
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         default: state_d = PARKED;
      endcase
   end

   always_ff @(posedge CP) begin
      if (RST) begin
         state_q     <= PARKED;
         cnt_q       <= '0;
         s_q         <= 2'b00;
         sel_valid_q <= 1'b0;
         cur_sel_q   <= 2'd0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         s_q         <= s_d;
         sel_valid_q <= sel_valid_d;
         cur_sel_q   <= cur_sel_d;
         err_q       <= err_d;
      end
   end

   assign bus.REQ_READY = req_ready;
   assign bus.S0        = s_q[0];
   assign bus.S1        = s_q[1];
   assign bus.SEL_VALID = sel_valid_q;
   assign bus.CUR_SEL   = cur_sel_q;
   assign bus.ERR       = err_q;

endmodule

// File: tb/tb_nem_ohmux_sel_seq_2i.sv
// Bench for the NEM relay select sequencer: a timestamp-based model of when each
// relay drives and settles, checked every cycle, plus directed literal checks.
module tb_nem_ohmux_sel_seq_2i;

   localparam int OFF_C = 3;
   localparam int ON_C  = 4;

   logic CP;
   logic RST;
   int   n_tests;
   int   n_fail;

   nem_ohmux_sel_seq_2i_if bus ();

   nem_ohmux_sel_seq_2i #(
      .OFF_CYCLES (OFF_C),
      .ON_CYCLES  (ON_C),
      .CNT_W      (8)
   ) dut (
      .CP  (CP),
      .RST (RST),
      .bus (bus.slave)
   );

   initial CP = 1'b0;
   always #5 CP = ~CP;

   // Model: a target code plus the edge numbers at which it starts driving and becomes valid.
   int   cyc;
   int   m_target;
   int   m_drive_from;
   int   m_valid_from;
   logic m_err;
   logic m_init;

   function automatic logic m_ready(int n);
      return (m_target == 0) ? (n >= m_drive_from) : (n >= m_valid_from);
   endfunction

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("[TB] FAIL %s at edge %0d: got %0d, expected %0d", name, cyc, act, exp);
      end
   endtask

   task automatic check_bit(input string name, input logic act, input logic exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s at edge %0d: got %b, expected %b", name, cyc, act, exp);
      end
   endtask

   initial begin
      cyc    = 0;
      m_init = 1'b0;
      m_err  = 1'b0;
      m_target = 0;
      m_drive_from = 0;
      m_valid_from = 0;
      forever begin
         logic rdy_pre;
         @(posedge CP);
         rdy_pre = m_ready(cyc);
         cyc++;
         if (RST) begin
            m_init       = 1'b1;
            m_target     = 0;
            m_drive_from = cyc;
            m_valid_from = cyc;
            m_err        = 1'b0;
         end else if (m_init && bus.REQ_VALID && rdy_pre) begin
            if (bus.REQ_SEL == 2'd3) begin
               m_err = 1'b1;
            end else if (int'(bus.REQ_SEL) != m_target) begin
               if (m_target == 0) begin
                  m_drive_from = cyc;
                  m_valid_from = cyc + ON_C;
               end else begin
                  m_drive_from = cyc + OFF_C;
                  m_valid_from = cyc + OFF_C + ON_C;
               end
               m_target = int'(bus.REQ_SEL);
            end
         end
      end
   end

   initial begin
      forever begin
         int  s_code;
         logic e_valid;
         @(negedge CP);
         if (m_init) begin
            s_code  = (cyc >= m_drive_from) ? m_target : 0;
            e_valid = (m_target != 0) && (cyc >= m_valid_from);
            check_bit("s0", bus.S0, s_code == 1);
            check_bit("s1", bus.S1, s_code == 2);
            check_bit("sel_valid", bus.SEL_VALID, e_valid);
            check("cur_sel", int'(bus.CUR_SEL), m_target);
            check_bit("err", bus.ERR, m_err);
            check_bit("req_ready", bus.REQ_READY, !RST && m_ready(cyc));
            check_bit("onehot", bus.S0 & bus.S1, 1'b0);
         end
      end
   end

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge CP);
         @(negedge CP);
      end
   endtask

   task automatic drive(input logic rst, input logic v, input logic [1:0] sel);
      #1;
      RST           = rst;
      bus.REQ_VALID = v;
      bus.REQ_SEL   = sel;
   endtask

   // Holds the request until the edge that accepts it, then drops it.
   task automatic apply_stimulus(input logic [1:0] code);
      bit done;
      done = 1'b0;
      drive(1'b0, 1'b1, code);
      for (int i = 0; i < 32 && !done; i++) begin
         if (bus.REQ_READY === 1'b1) done = 1'b1;
         step(1);
      end
      n_tests++;
      if (!done) begin
         n_fail++;
         $display("[TB] FAIL accept_timeout code %0d: got no REQ_READY, expected within 32 cycles", code);
      end
      drive(1'b0, 1'b0, 2'd0);
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      RST           = 1'b1;
      bus.REQ_VALID = 1'b0;
      bus.REQ_SEL   = 2'd0;
      @(negedge CP);
      step(2);
      check_bit("rst_ready", bus.REQ_READY, 1'b0);
      check_bit("rst_s0", bus.S0, 1'b0);
      check("rst_cur_sel", int'(bus.CUR_SEL), 0);
      drive(1'b0, 1'b0, 2'd0);
      step(1);
      check_bit("idle_ready", bus.REQ_READY, 1'b1);
      check_bit("idle_valid", bus.SEL_VALID, 1'b0);

      // Parked -> I0: valid exactly ON_C edges after S0 closes.
      apply_stimulus(2'd1);
      check_bit("k_s0", bus.S0, 1'b1);
      check_bit("k_ready", bus.REQ_READY, 1'b0);
      step(3);
      check_bit("k3_valid", bus.SEL_VALID, 1'b0);
      check_bit("k3_ready", bus.REQ_READY, 1'b0);
      step(1);
      check_bit("k4_valid", bus.SEL_VALID, 1'b1);
      check_bit("k4_ready", bus.REQ_READY, 1'b1);

      // I0 -> I1 through the open gap.
      apply_stimulus(2'd2);
      check_bit("sw_s0", bus.S0, 1'b0);
      check_bit("sw_valid", bus.SEL_VALID, 1'b0);
      step(2);
      check_bit("sw2_s1", bus.S1, 1'b0);
      step(1);
      check_bit("sw3_s1", bus.S1, 1'b1);
      step(3);
      check_bit("sw6_valid", bus.SEL_VALID, 1'b0);
      step(1);
      check_bit("sw7_valid", bus.SEL_VALID, 1'b1);

      // I1 -> park.
      apply_stimulus(2'd0);
      check_bit("pk_s1", bus.S1, 1'b0);
      step(2);
      check_bit("pk2_ready", bus.REQ_READY, 1'b0);
      step(1);
      check_bit("pk3_ready", bus.REQ_READY, 1'b1);
      check("pk3_cur_sel", int'(bus.CUR_SEL), 0);

      apply_stimulus(2'd3);
      check_bit("ill_park_err", bus.ERR, 1'b1);
      check_bit("ill_park_s0", bus.S0, 1'b0);

      // Back-to-back requests: the second is held until the first settles.
      apply_stimulus(2'd1);
      apply_stimulus(2'd2);
      check_bit("b2b_s0", bus.S0, 1'b0);
      check_bit("b2b_s1", bus.S1, 1'b0);
      step(7);
      check_bit("b2b_valid", bus.SEL_VALID, 1'b1);
      check_bit("b2b_s1_on", bus.S1, 1'b1);

      apply_stimulus(2'd3);
      check_bit("ill_st_err", bus.ERR, 1'b1);
      check_bit("ill_st_s1", bus.S1, 1'b1);
      check_bit("ill_st_valid", bus.SEL_VALID, 1'b1);
      apply_stimulus(2'd2);
      check_bit("same_valid", bus.SEL_VALID, 1'b1);
      check("same_cur_sel", int'(bus.CUR_SEL), 2);

      // Reset pulse in the open gap.
      apply_stimulus(2'd1);
      step(1);
      drive(1'b1, 1'b0, 2'd0);
      step(1);
      check_bit("mrst_s0", bus.S0, 1'b0);
      check_bit("mrst_s1", bus.S1, 1'b0);
      check_bit("mrst_valid", bus.SEL_VALID, 1'b0);
      check("mrst_cur_sel", int'(bus.CUR_SEL), 0);
      check_bit("mrst_err", bus.ERR, 1'b0);
      drive(1'b0, 1'b0, 2'd0);
      apply_stimulus(2'd1);
      check_bit("post_s0", bus.S0, 1'b1);
      step(3);
      check_bit("post3_valid", bus.SEL_VALID, 1'b0);
      step(1);
      check_bit("post4_valid", bus.SEL_VALID, 1'b1);

      step(2);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got no finish, expected end before 200000");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/nem_ohmux_sel_seq_2i.md
Name: nem_ohmux_sel_seq_2i

Overview:
- Select sequencer directly upstream of the 2-input inverting one-hot NEM relay mux (8-bit).
- Converts a registered select request into break-before-make S0/S1 drive, so both relays are never closed together.
- Honours relay mechanical release and pull-in settle times via cycle counters.
- Tells downstream logic when the mux output ZN is valid.

Parameters:
- OFF_CYCLES, 3, cycles S0=S1=0 is held after releasing a closed relay (release settle); legal range >=1.
- ON_CYCLES, 4, cycles a newly closed relay must settle before the output is declared valid; legal range >=1.
- CNT_W, 8, counter width; must hold max(OFF_CYCLES,ON_CYCLES)-1.

Ports:
- CP  input  1  clock, rising edge.
- RST  input  1  synchronous active-high reset.
- REQ_VALID  input  1  request present.
- REQ_SEL  input  2  request code: 0=park (no input), 1=I0 (S0), 2=I1 (S1), 3=illegal.
- REQ_READY  output  1  request accepted when REQ_VALID&REQ_READY at a rising CP edge.
- S0  output  1  relay select for I0, registered.
- S1  output  1  relay select for I1, registered.
- SEL_VALID  output  1  selected relay is closed and settled; ZN is valid.
- CUR_SEL  output  2  committed target code (0/1/2).
- ERR  output  1  sticky: an illegal code was accepted.

Behaviour:
- Reset is synchronous and active-high. With RST=1 at an edge: state PARKED, S0=S1=0, SEL_VALID=0, CUR_SEL=0, ERR=0, counter=0.
- REQ_READY is forced to 0 while RST=1.
- All outputs are registered except REQ_READY, which decodes combinationally from state: 1 in PARKED and STABLE, 0 otherwise.
- State PARKED: S=00, SEL_VALID=0.
  - Accepted code 0 is a no-op.
  - Accepted code 1 or 2: at that edge set S to the one-hot value, CUR_SEL=code, counter=ON_CYCLES-1, go to ON_WAIT.
- State ON_WAIT: S held, SEL_VALID=0.
  - Counter decrements each cycle.
  - At the edge where counter==0: go to STABLE, SEL_VALID=1.
  - Net effect: SEL_VALID rises exactly ON_CYCLES edges after S asserts.
- State STABLE: S held, SEL_VALID=1.
  - Accepted code equal to CUR_SEL is a no-op; SEL_VALID stays 1 without a glitch.
  - Accepted different legal code: at that edge set S=00 and SEL_VALID=0, latch new target into CUR_SEL, counter=OFF_CYCLES-1, go to OFF_WAIT.
- State OFF_WAIT: S=00, SEL_VALID=0.
  - Counter decrements each cycle.
  - At the edge where counter==0:
    - target 0: go to PARKED.
    - otherwise: assert the target select, counter=ON_CYCLES-1, go to ON_WAIT.
  - S=00 persists exactly OFF_CYCLES cycles.
- Illegal code 3, accepted in PARKED or STABLE: ERR<=1 (sticky until reset); state, S and CUR_SEL are unchanged.
- REQ_VALID while REQ_READY=0 is not accepted and has no effect. The requester holds the request until it is accepted.
- Invariant: S0&S1==0 in every cycle.
- Invariant: a transition from S0=1 to S1=1 (or back) always passes through at least OFF_CYCLES cycles of S=00.
- Invariant: SEL_VALID=1 implies S!=00.
- RST mid-sequence (ON_WAIT or OFF_WAIT): the next edge returns to PARKED with S=00 immediately. No settle wait is enforced after reset; the relays open from S=00.
- The counter never wraps: it is only decremented while nonzero in ON_WAIT/OFF_WAIT.

Test Plan:
- Reset then idle (OFF=3, ON=4):
  - S0=S1=0, SEL_VALID=0, CUR_SEL=0, ERR=0, REQ_READY=0 during RST, then 1 after.
- From PARKED, accept code 1 at edge k:
  - S0=1 from edge k.
  - REQ_READY=0 for edges k..k+3.
  - SEL_VALID=1 from edge k+4; REQ_READY=1 again.
- From STABLE on I0, accept code 2 at edge k:
  - S=00 and SEL_VALID=0 from k.
  - S1=1 at k+3.
  - SEL_VALID=1 at k+7.
  - Checker confirms S0&S1 never both 1.
- From STABLE on I1, accept code 0 at edge k:
  - S=00 from k.
  - PARKED and REQ_READY=1 at k+3.
- In STABLE, accept code 3:
  - ERR=1 permanently; S and SEL_VALID unchanged.
  - Then accept code equal to CUR_SEL: no state change, SEL_VALID stays 1.
- Assert RST one cycle during OFF_WAIT:
  - Next edge S=00, SEL_VALID=0, CUR_SEL=0, ERR=0.
  - After RST deasserts, a code 1 request completes normally with ON_CYCLES latency.
